// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Brief    : Group generate/propagate helper and configuration check for the
//            pipelined carry-lookahead adder.
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int c_MAX_GROUP = 64;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Collapse the low n bit-level g/p pairs into a single group G/P.
    function automatic gp_t group_gp(
        input logic [c_MAX_GROUP-1:0] g_bits,
        input logic [c_MAX_GROUP-1:0] p_bits,
        input int                     n
    );
        gp_t r;
        r.g = 1'b0;
        r.p = 1'b1;
        for (int j = 0; j < c_MAX_GROUP; j++) begin
            if (j < n) begin
                r.g = g_bits[j] | (p_bits[j] & r.g);
                r.p = r.p & p_bits[j];
            end
        end
        return r;
    endfunction

    function automatic bit cfg_ok(input int width, input int group, input int stages);
        return (group >= 1) && (group <= c_MAX_GROUP) && (stages >= 1) &&
               (width > 0) && ((width % (group * stages)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla_slice
// Brief    : Combinational W-bit carry-lookahead slice built from GROUP-bit groups.
// Revision : 1.0 - initial release
// ============================================================================
module cla_slice
    import cla_pkg::*;
#(
    parameter int W     = 16,
    parameter int GROUP = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_out,
    output logic         c_msb_in
);

    localparam int c_NG = W / GROUP;

    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [W-1:0]  w_c;
    logic [c_NG:0] w_gc;
    gp_t           w_gp;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group carries come from lookahead; bits inside a group ripple from the group carry.
    always_comb begin
        w_gc    = '0;
        w_c     = '0;
        w_gp    = '0;
        w_gc[0] = c_in;
        for (int gi = 0; gi < c_NG; gi++) begin
            w_gp = group_gp(c_MAX_GROUP'(w_g[gi*GROUP +: GROUP]),
                            c_MAX_GROUP'(w_p[gi*GROUP +: GROUP]), GROUP);
            w_gc[gi+1] = w_gp.g | (w_gp.p & w_gc[gi]);
            for (int j = 0; j < GROUP; j++) begin
                if (j == 0) begin
                    w_c[gi*GROUP] = w_gc[gi];
                end else begin
                    w_c[gi*GROUP+j] = w_g[gi*GROUP+j-1] |
                                      (w_p[gi*GROUP+j-1] & w_c[gi*GROUP+j-1]);
                end
            end
        end
    end

    assign s        = w_p ^ w_c;
    assign c_out    = w_gc[c_NG];
    assign c_msb_in = w_c[W-1];

endmodule
`default_nettype wire

// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder_pipe
// Brief    : Pipelined carry-lookahead add/subtract with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_SW   = WIDTH / STAGES;
    localparam int c_LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_cfg_check
        $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of GROUP*STAGES");
    end

    logic [STAGES:0]                w_ready;
    logic [STAGES-1:0]              w_v;
    logic [STAGES-1:0]              w_c;
    logic [STAGES-1:0][WIDTH-1:0]   w_a;
    logic [STAGES-1:0][WIDTH-1:0]   w_b;

    assign w_ready[STAGES] = out_ready;
    assign in_ready        = w_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_LO = k * c_SW;

        logic             w_vin;
        logic             w_cin;
        logic [WIDTH-1:0] w_ain;
        logic [WIDTH-1:0] w_bin;
        logic [WIDTH-1:0] w_na;
        logic [WIDTH-1:0] w_nb;
        logic [c_SW-1:0]  w_s;
        logic             w_cout;
        logic             w_cmsb;
        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;

        if (k == 0) begin : g_head
            assign w_vin = in_valid;
            assign w_ain = a;
            assign w_bin = sub ? ~b : b;
            assign w_cin = sub | cin;
        end else begin : g_body
            assign w_vin = w_v[k-1];
            assign w_ain = w_a[k-1];
            assign w_bin = w_b[k-1];
            assign w_cin = w_c[k-1];
        end

        cla_slice #(
            .W     (c_SW),
            .GROUP (GROUP)
        ) u_slice (
            .a        (w_ain[c_LO +: c_SW]),
            .b        (w_bin[c_LO +: c_SW]),
            .c_in     (w_cin),
            .s        (w_s),
            .c_out    (w_cout),
            .c_msb_in (w_cmsb)
        );

        // The a word carries finished sum bits below the slice; finished b bits are
        // cleared, so xor-ing them in leaves those sum bits untouched.
        always_comb begin
            w_na = w_ain;
            w_nb = w_bin;
            for (int i = 0; i < WIDTH; i++) begin
                if (i < c_LO) begin
                    w_na[i] = w_ain[i] ^ w_bin[i];
                end
                if (i < c_LO + c_SW) begin
                    w_nb[i] = 1'b0;
                end
            end
            w_na[c_LO +: c_SW] = w_s;
        end

        assign w_ready[k] = !r_v || w_ready[k+1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_a <= '0;
                r_b <= '0;
            end else if (w_ready[k]) begin
                r_v <= w_vin;
                if (w_vin) begin
                    r_a <= w_na;
                    r_b <= w_nb;
                    r_c <= w_cout;
                end
            end
        end

        assign w_v[k] = r_v;
        assign w_c[k] = r_c;
        assign w_a[k] = r_a;
        assign w_b[k] = r_b;

        if (k == c_LAST) begin : g_tail
            logic r_ovf;
            logic w_unused_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_ready[k] && w_vin) begin
                    r_ovf <= w_cmsb ^ w_cout;
                end
            end

            assign ovf        = r_ovf;
            assign w_unused_b = ^r_b;
        end else begin : g_mid
            logic w_unused_cmsb;
            assign w_unused_cmsb = w_cmsb;
        end
    end

    assign out_valid = w_v[c_LAST];
    assign cout      = w_c[c_LAST];
    assign sum       = w_a[c_LAST];

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_adder_pipe
// Brief    : Self-checking bench for cla_adder_pipe (WIDTH=32, GROUP=4, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_adder_pipe;

    localparam int c_STAGES = 2;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic [31:0] acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    exp_t        q[$];
    exp_t        pend;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    bit          lat_on;
    bit          accepted;

    always #5 clk = ~clk;

    cla_adder_pipe #(
        .WIDTH  (32),
        .GROUP  (4),
        .STAGES (c_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed range test for overflow, unsigned compare for carry/borrow.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        exp_t            e;
        longint          st;
        longint unsigned ut;
        if (sb) begin
            st  = longint'($signed(x)) - longint'($signed(y));
            ut  = 64'(x) - 64'(y);
            e.c = (x >= y);
        end else begin
            st  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            ut  = 64'(x) + 64'(y) + 64'(ci);
            e.c = ut[32];
        end
        e.s   = ut[31:0];
        e.o   = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        e.acc = 32'd0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_op(input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic sb, input exp_t e);
        a    = x;
        b    = y;
        cin  = ci;
        sub  = sb;
        pend = e;
    endtask

    task automatic set_rand_op();
        logic [31:0] x;
        logic [31:0] y;
        logic        ci;
        logic        sb;
        x  = pick();
        y  = pick();
        ci = 1'($urandom);
        sb = 1'($urandom);
        set_op(x, y, ci, sb, model(x, y, ci, sb));
    endtask

    // One clock: drive handshake, score the output side, record accepts, advance.
    task automatic cycle(input logic v, input logic ordy);
        in_valid  = v;
        out_ready = ordy;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("sum", 64'(sum), 64'(q[0].s));
                chk("cout", 64'(cout), 64'(q[0].c));
                chk("ovf", 64'(ovf), 64'(q[0].o));
                if (ordy) begin
                    if (lat_on) chk("latency", 64'(cyc - q[0].acc), 64'(c_STAGES));
                    q.delete(0);
                end
            end
        end
        accepted = v && in_ready;
        if (accepted) begin
            pend.acc = cyc;
            q.push_back(pend);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] ta [5] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_0005,
                                32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] tb [5] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0007,
                                32'h0000_0001, 32'h0000_0001};
        logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_t        te [5] = '{'{s: 32'h0001_0000, c: 1'b0, o: 1'b0, acc: 32'd0},
                                '{s: 32'h0000_0000, c: 1'b1, o: 1'b0, acc: 32'd0},
                                '{s: 32'hFFFF_FFFE, c: 1'b0, o: 1'b0, acc: 32'd0},
                                '{s: 32'h8000_0000, c: 1'b0, o: 1'b1, acc: 32'd0},
                                '{s: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1, acc: 32'd0}};
        int n_acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        pend      = '0;
        lat_on    = 1'b0;

        @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases, then 8 random ops, all back-to-back.
        lat_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_op(ta[i], tb[i], tc[i], ts[i], te[i]);
            cycle(1'b1, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            set_rand_op();
            cycle(1'b1, 1'b1);
            chk("b2b_accept", 64'(accepted), 64'd1);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        chk("directed_drained", 64'(q.size()), 64'd0);

        // Backpressure: consumer stalls for 5 cycles with operands always offered.
        lat_on = 1'b0;
        n_acc  = 0;
        set_rand_op();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0);
            if (accepted) begin
                n_acc++;
                set_rand_op();
            end
        end
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_accepts", 64'(n_acc), 64'd2);
        chk("stall_queue", 64'(q.size()), 64'd2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        chk("stall_drained", 64'(q.size()), 64'd0);

        // Asynchronous reset with two ops in flight.
        set_rand_op();
        cycle(1'b1, 1'b1);
        set_rand_op();
        cycle(1'b1, 1'b1);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        chk("rst_no_ghost", 64'(out_valid), 64'd0);
        lat_on = 1'b1;
        set_rand_op();
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        chk("post_rst_drained", 64'(q.size()), 64'd0);

        // Random traffic with random valid/ready.
        lat_on = 1'b0;
        n_acc  = 0;
        set_rand_op();
        for (int i = 0; i < 6000 && n_acc < 2000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            if (accepted) begin
                n_acc++;
                set_rand_op();
            end
        end
        chk("random_accepts", 64'(n_acc), 64'd2000);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
